// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 clause-22/45 MDIO management master with
// programmable MDC divider, preamble length and response handshake.
module mdio_master #(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_25M,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        rsp_cmd_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] D_RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [5:0]    P_LAST = 6'(PREAMBLE_LEN - 1);

  if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_div_chk
    $error("mdio_master: CLK_DIV must be even and at least 4");
  end
  if (PREAMBLE_LEN < 0 || PREAMBLE_LEN > 32) begin : g_pre_chk
    $error("mdio_master: PREAMBLE_LEN must be 0..32");
  end

  typedef enum logic [3:0] {
    IDLE, PRE, ST, OP, PAD, RAD, TA, DATA, FIN, CERR
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    last;
  logic [31:0]   tx_sr;
  logic [31:0]   sr_n;
  logic [31:0]   frame;
  logic [15:0]   rx_sr;
  logic          rd;
  logic          ta_bit;
  logic          cmd_rd;
  logic          cmd_bad;
  logic          bnd;
  logic          adv;

  assign busy    = (state != IDLE);
  assign cmd_rd  = cmd_c45 ? cmd_op[1] : (cmd_op == 2'b10);
  assign cmd_bad = !cmd_c45 && (cmd_op[1] == cmd_op[0]);
  // ST..DATA; read frames carry ones where the PHY drives
  assign frame   = {1'b0, !cmd_c45, cmd_op,
                    cmd_phy_addr, cmd_reg_addr,
                    cmd_rd ? 18'h3FFFF
                           : {2'b10, cmd_wdata}};

  always_comb begin
    last   = 6'd0;
    nstate = IDLE;
    unique case (state)
      PRE:  begin last = P_LAST; nstate = ST;   end
      ST:   begin last = 6'd1;   nstate = OP;   end
      OP:   begin last = 6'd1;   nstate = PAD;  end
      PAD:  begin last = 6'd4;   nstate = RAD;  end
      RAD:  begin last = 6'd4;   nstate = TA;   end
      TA:   begin last = 6'd1;   nstate = DATA; end
      DATA: begin last = 6'd15;  nstate = FIN;  end
      default: ;
    endcase
    bnd = (div_cnt == D_LAST);
    adv = bnd && (bit_cnt == last);
    if (!adv) nstate = state;
    // leaving PRE presents the first ST bit unshifted
    sr_n = (state == PRE) ? tx_sr
                          : {tx_sr[30:0], 1'b1};
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rd          <= 1'b0;
      ta_bit      <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_ta_err  <= 1'b0;
      rsp_cmd_err <= 1'b0;
      mdc         <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        cmd_ready <= 1'b1;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        mdc       <= 1'b0;
        mdio_o    <= 1'b1;
        mdio_oe   <= 1'b0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          rd        <= cmd_rd;
          tx_sr     <= frame;
          if (cmd_bad) begin
            state <= CERR;
          end else begin
            state   <= (PREAMBLE_LEN > 0) ? PRE : ST;
            mdio_o  <= (PREAMBLE_LEN > 0) ? 1'b1
                                          : frame[31];
            mdio_oe <= 1'b1;
          end
        end
      end else if (state == CERR) begin
        state       <= IDLE;
        cmd_ready   <= 1'b1;
        rsp_valid   <= 1'b1;
        rsp_cmd_err <= 1'b1;
        rsp_ta_err  <= 1'b0;
      end else begin
        if (div_cnt == D_HALF) begin
          if (state == TA && bit_cnt == 6'd1)
            ta_bit <= mdio_i;
          if (state == DATA)
            rx_sr <= {rx_sr[14:0], mdio_i};
        end
        if (bnd) begin
          div_cnt <= '0;
          mdc     <= 1'b0;
          bit_cnt <= adv ? 6'd0 : bit_cnt + 6'd1;
          state   <= nstate;
          tx_sr   <= sr_n;
          if (nstate == PRE) begin
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b1;
          end else if (nstate == FIN || nstate == IDLE ||
                       (rd && (nstate == TA ||
                               nstate == DATA))) begin
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
          end else begin
            mdio_o  <= sr_n[31];
            mdio_oe <= 1'b1;
          end
          if (state == FIN) begin
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_cmd_err <= 1'b0;
            rsp_ta_err  <= rd & ta_bit;
            if (rd) rsp_rdata <= rx_sr;
          end
        end else begin
          div_cnt <= div_cnt + D_ONE;
          mdc     <= (div_cnt >= D_RISE);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed checks of the MDIO master against a
// behavioural PHY, default divider and a fast clause-45 setup.
module tb_mdio_master;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst;
  logic        cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        va, vb;

  logic        ready_a, rv_a, ta_a, ce_a, busy_a;
  logic        mdc_a, mo_a, moe_a, mi_a;
  logic [15:0] rdata_a;
  logic        ready_b, rv_b, ta_b, ce_b, busy_b;
  logic        mdc_b, mo_b, moe_b, mi_b;
  logic [15:0] rdata_b;

  mdio_master u_a (
    .clk_25M(clk), .rst(rst),
    .cmd_valid(va), .cmd_ready(ready_a),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rdata_a),
    .rsp_ta_err(ta_a), .rsp_cmd_err(ce_a),
    .busy(busy_a), .mdc(mdc_a),
    .mdio_o(mo_a), .mdio_oe(moe_a), .mdio_i(mi_a)
  );

  mdio_master #(.CLK_DIV(8), .PREAMBLE_LEN(0)) u_b (
    .clk_25M(clk), .rst(rst),
    .cmd_valid(vb), .cmd_ready(ready_b),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rdata_b),
    .rsp_ta_err(ta_b), .rsp_cmd_err(ce_b),
    .busy(busy_b), .mdc(mdc_b),
    .mdio_o(mo_b), .mdio_oe(moe_b), .mdio_i(mi_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // PHY model: bit index k counts MDC rising edges since the frame
  // started; it drives TA2 and DATA on the MDC falling edge.
  logic        clr_a, clr_b;
  logic        mdc_a_q, mdc_b_q;
  logic [63:0] sr_a, sr_b;
  int          edges_a, oe_a, edges_b, oe_b;
  logic [15:0] pv_a, pv_b;
  logic        pta_a, pta_b;

  function automatic logic phy_bit(int k, int p,
                                   logic [15:0] v, logic ta);
    if (k == p + 15) return ta;
    if (k >= p + 16 && k < p + 32)
      return v[15 - (k - p - 16)];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    mdc_a_q <= mdc_a;
    if (clr_a) begin
      sr_a <= '0; edges_a <= 0; oe_a <= 0; mi_a <= 1'b1;
    end else if (mdc_a && !mdc_a_q) begin
      edges_a <= edges_a + 1;
      if (moe_a) begin
        sr_a <= {sr_a[62:0], mo_a};
        oe_a <= oe_a + 1;
      end
    end else if (!mdc_a && mdc_a_q) begin
      mi_a <= phy_bit(edges_a, 32, pv_a, pta_a);
    end
  end

  always @(posedge clk) begin
    mdc_b_q <= mdc_b;
    if (clr_b) begin
      sr_b <= '0; edges_b <= 0; oe_b <= 0; mi_b <= 1'b1;
    end else if (mdc_b && !mdc_b_q) begin
      edges_b <= edges_b + 1;
      if (moe_b) begin
        sr_b <= {sr_b[62:0], mo_b};
        oe_b <= oe_b + 1;
      end
    end else if (!mdc_b && mdc_b_q) begin
      mi_b <= phy_bit(edges_b, 0, pv_b, pta_b);
    end
  end

  task automatic send(input bit b, input logic c45,
                      input logic [1:0] op,
                      input logic [4:0] pa,
                      input logic [4:0] ra,
                      input logic [15:0] wd);
    int n;
    cmd_c45 = c45; cmd_op = op;
    cmd_phy_addr = pa; cmd_reg_addr = ra;
    cmd_wdata = wd;
    if (b) begin vb = 1'b1; clr_b = 1'b1; end
    else begin va = 1'b1; clr_a = 1'b1; end
    n = 0;
    while (!(b ? ready_b : ready_a) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 64'(n < 2000), 64'd1);
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  // lat = cycle index of rsp_valid, acceptance edge closing cycle T
  task automatic wait_rsp(input bit b, output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(b ? rv_b : rv_a) && n < 3000);
    chk("rsp_seen", 64'(b ? rv_b : rv_a), 64'd1);
    lat = n + 1;
  endtask

  initial begin
    int lat;
    int n;
    int cnt;
    rst = 1'b1; va = 1'b0; vb = 1'b0;
    clr_a = 1'b1; clr_b = 1'b1;
    cmd_c45 = 1'b0; cmd_op = 2'b00;
    cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    pv_a = 16'h796D; pta_a = 1'b0;
    pv_b = 16'hBEEF; pta_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a",
        64'({ready_a, busy_a, rv_a, ta_a, ce_a,
             mdc_a, moe_a, mo_a, rdata_a}),
        64'({8'b0000_0001, 16'h0000}));
    chk("reset_b",
        64'({ready_b, busy_b, rv_b, ta_b, ce_b,
             mdc_b, moe_b, mo_b, rdata_b}),
        64'({8'b0000_0001, 16'h0000}));
    rst = 1'b0;
    chk("ready_after_rst_low", 64'(ready_a), 64'd0);
    @(posedge clk); #1;
    chk("ready_rise_a", 64'(ready_a), 64'd1);
    chk("ready_rise_b", 64'(ready_b), 64'd1);
    clr_a = 1'b0; clr_b = 1'b0;

    // C22 write PHYAD 1 REGAD 0 data 0x1140
    send(0, 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140);
    wait_rsp(0, lat);
    chk("wr_latency", 64'(lat), 64'd261);
    chk("wr_ready_at_rsp", 64'(ready_a), 64'd1);
    chk("wr_errs", 64'({ce_a, ta_a}), 64'd0);
    chk("wr_rdata_kept", 64'(rdata_a), 64'h0);
    chk("wr_stream", sr_a, 64'hFFFF_FFFF_5082_1140);
    chk("wr_oe_bits", 64'(oe_a), 64'd64);
    chk("wr_mdc_edges", 64'(edges_a), 64'd65);
    @(posedge clk); #1;
    chk("rsp_one_cycle", 64'(rv_a), 64'd0);
    chk("idle_pins", 64'({mdc_a, moe_a, mo_a}), 64'b001);

    // C22 read, PHY answers 0x796D
    send(0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0);
    wait_rsp(0, lat);
    chk("rd_latency", 64'(lat), 64'd261);
    chk("rd_data", 64'(rdata_a), 64'h796D);
    chk("rd_errs", 64'({ce_a, ta_a}), 64'd0);
    chk("rd_oe_bits", 64'(oe_a), 64'd46);

    // C22 read with no PHY: line pulled high
    pv_a = 16'hFFFF; pta_a = 1'b1;
    send(0, 1'b0, 2'b10, 5'h07, 5'h01, 16'h0);
    wait_rsp(0, lat);
    chk("nophy_ta_err", 64'(ta_a), 64'd1);
    chk("nophy_data", 64'(rdata_a), 64'hFFFF);

    // illegal C22 op 11
    send(0, 1'b0, 2'b11, 5'h01, 5'h01, 16'h0);
    wait_rsp(0, lat);
    chk("bad_latency", 64'(lat), 64'd2);
    chk("bad_errs", 64'({ce_a, ta_a}), 64'b10);
    chk("bad_no_mdc", 64'(edges_a), 64'd0);
    chk("bad_rdata_kept", 64'(rdata_a), 64'hFFFF);

    // reset during DATA of a read
    pv_a = 16'h796D; pta_a = 1'b0;
    send(0, 1'b0, 2'b10, 5'h01, 5'h03, 16'h0);
    n = 0;
    while (edges_a < 52 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_in_data", 64'(edges_a >= 52), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_pins",
        64'({mdc_a, moe_a, mo_a, busy_a, ready_a}),
        64'b00100);
    chk("abort_rdata", 64'(rdata_a), 64'h0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rv_a) cnt++;
    end
    chk("abort_no_rsp", 64'(cnt), 64'd0);
    send(0, 1'b0, 2'b01, 5'h02, 5'h04, 16'hA5A5);
    wait_rsp(0, lat);
    chk("post_abort_latency", 64'(lat), 64'd261);
    chk("post_abort_errs", 64'({ce_a, ta_a}), 64'd0);
    chk("post_abort_stream", sr_a[31:0], 64'h5112_A5A5);
    chk("post_abort_rdata", 64'(rdata_a), 64'h0);

    // C45 address then back-to-back read, CLK_DIV 8, no preamble
    send(1, 1'b1, 2'b00, 5'h03, 5'h01, 16'h0002);
    wait_rsp(1, lat);
    chk("c45a_latency", 64'(lat), 64'd265);
    chk("c45a_stream", sr_b, 64'h0186_0002);
    chk("c45a_oe_bits", 64'(oe_b), 64'd32);
    chk("c45a_edges", 64'(edges_b), 64'd33);
    chk("c45a_errs", 64'({ce_b, ta_b}), 64'd0);
    chk("c45a_ready_at_rsp", 64'(ready_b), 64'd1);
    cmd_c45 = 1'b1; cmd_op = 2'b11;
    cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h01;
    vb = 1'b1; clr_b = 1'b1;
    @(posedge clk); #1;
    vb = 1'b0; clr_b = 1'b0;
    chk("c45r_accepted",
        64'({busy_b, ready_b}), 64'b10);
    wait_rsp(1, lat);
    chk("c45r_latency", 64'(lat), 64'd265);
    chk("c45r_data", 64'(rdata_b), 64'hBEEF);
    chk("c45r_errs", 64'({ce_b, ta_b}), 64'd0);
    chk("c45r_oe_bits", 64'(oe_b), 64'd14);
    chk("c45r_stream", 64'(sr_b[13:0]), 64'h0C61);
    chk("c45r_edges", 64'(edges_b), 64'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
